// File: rtl/universal_shift_register_pkg.sv
// Shared definitions for the universal shift register: operating-mode encodings.
package universal_shift_register_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/universal_shift_register_shift_cell.sv
// One storage bit of the universal shift register: 4:1 next-state mux,
// clock enable, synchronous reset to a per-bit value, rising-edge flop.
module shift_cell
  import universal_shift_register_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       c,
  input  logic       r,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       from_hi,
  input  logic       from_lo,
  input  logic       d,
  output logic       q
);

  logic q_reg;
  logic q_next;

  // from_hi feeds a right shift (bit i takes bit i+1), from_lo a left shift.
  always_comb begin
    q_next = q_reg;
    if (en) begin
      case (mode)
        MODE_HOLD: q_next = q_reg;
        MODE_SHR:  q_next = from_hi;
        MODE_SHL:  q_next = from_lo;
        MODE_LOAD: q_next = d;
        default:   q_next = q_reg;
      endcase
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      q_reg <= RESET_BIT;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load)
// assembled from per-bit shift_cell instances.
module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             c,
  input  logic             r,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sr_in,
  input  logic             sl_in,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             so_r,
  output logic             so_l
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] from_hi;
  logic [WIDTH-1:0] from_lo;

  // End cells take the serial inputs as their missing neighbour.
  assign from_hi = {sr_in, q_reg[WIDTH-1:1]};
  assign from_lo = {q_reg[WIDTH-2:0], sl_in};

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      shift_cell #(
        .RESET_BIT(RESET_VALUE[gi])
      ) u_cell (
        .c      (c),
        .r      (r),
        .en     (en),
        .mode   (mode),
        .from_hi(from_hi[gi]),
        .from_lo(from_lo[gi]),
        .d      (d[gi]),
        .q      (q_reg[gi])
      );
    end
  endgenerate

  assign Q    = q_reg;
  assign Qn   = ~q_reg;
  assign so_r = q_reg[0];
  assign so_l = q_reg[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench: stimulus pushes model-predicted register contents, an
// independent monitor pops and compares them after each rising edge.
module tb_universal_shift_register;
  import universal_shift_register_pkg::*;

  localparam int W = 4;
  localparam logic [W-1:0] RV = 4'b0000;

  typedef struct {
    logic [W-1:0] q;
    string        name;
  } exp_t;

  logic         c = 1'b0;
  logic         r = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = MODE_HOLD;
  logic [W-1:0] d = '0;
  logic         sr_in = 1'b0;
  logic         sl_in = 1'b0;
  logic [W-1:0] Q;
  logic [W-1:0] Qn;
  logic         so_r;
  logic         so_l;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           txn = 0;
  logic [W-1:0] model_q;

  universal_shift_register #(
    .WIDTH(W),
    .RESET_VALUE(RV)
  ) dut (
    .c(c), .r(r), .en(en), .mode(mode), .d(d),
    .sr_in(sr_in), .sl_in(sl_in),
    .Q(Q), .Qn(Qn), .so_r(so_r), .so_l(so_l)
  );

  always #5 c = ~c;

  // Reference behaviour expressed as whole-word arithmetic.
  function automatic logic [W-1:0] predict(input logic [W-1:0] q, input logic rr, input logic ee,
                                           input logic [1:0] mm, input logic [W-1:0] dd,
                                           input logic ss, input logic ll);
    int unsigned v;
    int unsigned mask;
    mask = (1 << W) - 1;
    v = int'(q);
    if (rr) return RV;
    if (!ee) return q;
    case (mm)
      2'd1: v = (v >> 1) | (int'(ss) << (W - 1));
      2'd2: v = ((v << 1) | int'(ll)) & mask;
      2'd3: v = int'(dd);
      default: v = int'(q);
    endcase
    return v[W-1:0];
  endfunction

  task automatic step(input logic rr, input logic ee, input logic [1:0] mm, input logic [W-1:0] dd,
                      input logic ss, input logic ll, input bit tie_sl, input bit glitch,
                      input string nm);
    exp_t e;
    @(negedge c);
    #1;
    r = rr; en = ee; mode = mm; d = dd; sr_in = ss;
    sl_in = tie_sl ? so_l : ll;
    model_q = predict(model_q, r, en, mode, d, sr_in, sl_in);
    e.q = model_q;
    e.name = nm;
    sb.push_back(e);
    if (glitch) begin
      // Disturb every input between edges; the register must ignore it.
      @(posedge c);
      #3;
      d = ~d; sr_in = ~sr_in; sl_in = ~sl_in; mode = ~mode; en = ~en;
    end
  endtask

  task automatic check(input exp_t e, input string phase);
    total++;
    if (Q !== e.q || Qn !== ~e.q || so_r !== e.q[0] || so_l !== e.q[W-1]) begin
      bad++;
      $display("FAIL %s/%s: Q=%b Qn=%b so_r=%b so_l=%b, required Q=%b Qn=%b so_r=%b so_l=%b",
               e.name, phase, Q, Qn, so_r, so_l, e.q, ~e.q, e.q[0], e.q[W-1]);
    end
  endtask

  // Monitor: one expected result per rising edge, checked shortly after the
  // edge and again later in the cycle (after any mid-cycle input glitch).
  initial begin
    exp_t e;
    forever begin
      @(posedge c);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d %s: Q=%b expected=%b", txn, e.name, Q, e.q);
        check(e, "settle");
        #2;
        check(e, "late");
      end
    end
  end

  initial begin
    model_q = 'x;
    // Reset dominates en/mode/d.
    step(1, 1, MODE_LOAD, 4'b1111, 0, 0, 0, 0, "reset");
    // Load and hold.
    step(0, 1, MODE_LOAD, 4'b1010, 0, 0, 0, 0, "load");
    for (int i = 0; i < 3; i++) step(0, 1, MODE_HOLD, 4'b0101, 0, 0, 0, 0, "hold");
    step(0, 0, MODE_LOAD, 4'b0101, 0, 0, 0, 0, "en_off");
    // Shift right with sr_in=1: 1101 then 1110.
    for (int i = 0; i < 2; i++) step(0, 1, MODE_SHR, 4'b0000, 1, 0, 0, 0, "shr");
    // Shift left from 0001 with sl_in=0.
    step(0, 1, MODE_LOAD, 4'b0001, 0, 0, 0, 0, "load");
    for (int i = 0; i < 4; i++) step(0, 1, MODE_SHL, 4'b0000, 0, 0, 0, 0, "shl");
    // Rotate left via sl_in tied to so_l, with inputs glitched mid-cycle.
    step(0, 1, MODE_LOAD, 4'b1000, 0, 0, 0, 0, "load");
    for (int i = 0; i < 4; i++) step(0, 1, MODE_SHL, 4'b0000, 0, 0, 1, 1, "rotate");
    // Reset mid-operation, then reload.
    step(0, 1, MODE_SHR, 4'b0000, 1, 0, 0, 0, "shr");
    step(1, 1, MODE_SHR, 4'b0000, 1, 0, 0, 0, "mid_reset");
    step(0, 1, MODE_LOAD, 4'b0110, 0, 0, 0, 0, "reload");
    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), "random");
    end
    repeat (3) @(negedge c);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: outstanding=%0d, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
